ysyx_mem_arbiter: RTL and testbench
===================================

Name: ysyx_mem_arbiter

Overview:
Shares the single core memory port between instruction fetch (IFU) and the EXU load/store path (lsu_avalid_o/lsu_mem_wdata_o side). It grants one requester at a time and drives one transaction downstream. It returns the read data or the write acknowledge to the granted requester only. LSU has priority; a streak counter guarantees IFU forward progress, and a watchdog aborts hung transactions.

Parameters:
BIT_W, 32, data/address width (matches `YSYX_W_WIDTH)
MAX_LSU_STREAK, 4, consecutive LSU grants allowed while IFU waits; range 1..15
TIMEOUT, 255, cycles a transaction may spend in ADDR+RESP before abort; range 1..255 (8-bit counter)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
ifu_avalid_i  in  1  fetch request; held high until ifu_rvalid_o
ifu_addr_i  in  BIT_W  fetch address
ifu_rvalid_o  out  1  fetch response pulse
ifu_rdata_o  out  BIT_W  fetch data; valid with ifu_rvalid_o
lsu_avalid_i  in  1  load/store request; held until response
lsu_wen_i  in  1  1=store, 0=load
lsu_addr_i  in  BIT_W  load/store address
lsu_wdata_i  in  BIT_W  store data
lsu_wstrb_i  in  BIT_W/8  store byte strobes
lsu_rvalid_o  out  1  load response pulse
lsu_wready_o  out  1  store acknowledge pulse
lsu_rdata_o  out  BIT_W  load data
err_o  out  1  pulses with any response that ended in timeout
mem_avalid_o  out  1  downstream request valid
mem_aready_i  in  1  downstream request accepted
mem_wen_o  out  1  downstream store
mem_addr_o  out  BIT_W  downstream address
mem_wdata_o  out  BIT_W  downstream store data
mem_wstrb_o  out  BIT_W/8  downstream strobes
mem_rvalid_i  in  1  downstream read data valid
mem_rdata_i  in  BIT_W  downstream read data
mem_bvalid_i  in  1  downstream write complete

Behaviour:
- Reset, asynchronous, when rst=0: state=IDLE, grant=NONE, streak=0, wdog=0. All outputs are 0, including the data and address registers.
- States:
  - IDLE: sample requests. If any request is pending, latch the grant, addr, wdata, wstrb and wen, then go to ADDR next cycle.
  - ADDR: mem_avalid_o=1 with the latched fields. On mem_aready_i, go to RESP.
  - RESP: wait for the completion input of the granted request.
    - Load or fetch: on mem_rvalid_i, register mem_rdata_i to the granted requester's rdata output and pulse its rvalid for one cycle.
    - Store: on mem_bvalid_i, pulse lsu_wready_o for one cycle.
    - In either case, return to IDLE.
- Response outputs are registered; the pulse appears the cycle after mem_rvalid_i/mem_bvalid_i. The rdata output holds its value until the next response to that requester.
- The next grant is decided in IDLE only. Minimum request-to-response latency is 4 cycles with zero-wait memory (IDLE sample, ADDR, RESP, response).
- Completion inputs are ignored in IDLE and ADDR; an unexpected mem_rvalid_i or mem_bvalid_i is dropped.
- Arbitration in IDLE:
  - Only one requester pending: grant it.
  - Both pending: grant LSU unless streak==MAX_LSU_STREAK, in which case grant IFU.
- Streak counter:
  - Increments on an LSU grant while ifu_avalid_i=1.
  - Clears on any IFU grant, and whenever ifu_avalid_i=0 in IDLE.
  - Saturates at MAX_LSU_STREAK.
- Watchdog:
  - wdog clears on entry to ADDR and increments each cycle in ADDR/RESP.
  - When wdog==TIMEOUT-1 and the transaction has not completed, the transaction is aborted:
    - mem_avalid_o drops.
    - The granted requester gets its normal response pulse with rdata=0 and err_o=1 in the same cycle.
    - State returns to IDLE.
  - If completion and timeout occur in the same cycle, completion wins and err_o=0.
- Stores never update lsu_rdata_o. A fetch response never asserts lsu_* outputs, and vice versa.
- A requester dropping avalid mid-transaction does not cancel it; the response is still pulsed.
- A reset asserted mid-transaction abandons it immediately, with no response pulse.

Decomposition:
- Shared package ysyx_pkg:
  - grant enum {GNT_NONE, GNT_IFU, GNT_LSU}
  - arbiter state enum {ARB_IDLE, ARB_ADDR, ARB_RESP}
  - width constant tied to `YSYX_W_WIDTH
- One natural sub-module, ysyx_arb_prio: combinational priority-plus-streak grant select. Inputs are the two requests and streak==MAX; output is the grant. Streak and watchdog registers stay in the parent.

Test Plan:
- Fetch at 0x8000_0000, zero-wait memory returning 0x0000_0413 -> ifu_rvalid_o pulses 4 cycles after request with ifu_rdata_o=0x0000_0413; lsu_* stay 0.
- Store addr 0x8000_1000, wdata 0xDEADBEEF, wstrb 0xF; bvalid 2 cycles after aready -> mem_wen_o=1 with those fields during ADDR; lsu_wready_o pulses once; lsu_rdata_o unchanged.
- IFU and LSU both held high continuously, MAX_LSU_STREAK=4 -> grant sequence LSU,LSU,LSU,LSU,IFU,LSU,... repeating.
- mem_aready_i never asserted, TIMEOUT=8, LSU load pending -> mem_avalid_o high 8 cycles, then lsu_rvalid_o=1, err_o=1, lsu_rdata_o=0; next request is served normally.
- mem_rvalid_i in the same cycle wdog hits TIMEOUT-1 -> normal response with err_o=0 and real data.
- rst driven low mid-RESP with no clock edge -> all outputs 0 immediately; after release, a stale mem_rvalid_i is ignored and no response pulse occurs.

Source files
------------

// File: rtl/ysyx_pkg.sv
// Shared types and widths for the ysyx memory arbiter slice.
// The core data/address width is taken from `YSYX_W_WIDTH when the build defines it.
`ifndef YSYX_W_WIDTH
`define YSYX_W_WIDTH 32
`endif

package ysyx_pkg;

    localparam int YSYX_W   = `YSYX_W_WIDTH;
    localparam int STREAK_W = 4;
    localparam int WDOG_W   = 8;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_IFU,
        GNT_LSU
    } grant_e;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ADDR,
        ARB_RESP
    } arb_state_e;

endpackage

// File: rtl/ysyx_mem_arbiter_if.sv
// Downstream core memory port: one request channel plus read-data and write-complete returns.
interface ysyx_mem_arbiter_if #(
    parameter int BIT_W = ysyx_pkg::YSYX_W
);

    logic               avalid;
    logic               aready;
    logic               wen;
    logic [BIT_W-1:0]   addr;
    logic [BIT_W-1:0]   wdata;
    logic [BIT_W/8-1:0] wstrb;
    logic               rvalid;
    logic [BIT_W-1:0]   rdata;
    logic               bvalid;

    modport master (
        output avalid,
        output wen,
        output addr,
        output wdata,
        output wstrb,
        input  aready,
        input  rvalid,
        input  rdata,
        input  bvalid
    );

    modport slave (
        input  avalid,
        input  wen,
        input  addr,
        input  wdata,
        input  wstrb,
        output aready,
        output rvalid,
        output rdata,
        output bvalid
    );

endinterface

// File: rtl/ysyx_arb_prio.sv
// Grant select: LSU wins a tie unless it has used up its streak while IFU waits.
module ysyx_arb_prio
    import ysyx_pkg::*;
(
    input  logic   ifu_req,
    input  logic   lsu_req,
    input  logic   streak_max,
    output grant_e grant
);

    always_comb begin
        grant = GNT_NONE;
        if (lsu_req && !(ifu_req && streak_max)) begin
            grant = GNT_LSU;
        end else if (ifu_req) begin
            grant = GNT_IFU;
        end
    end

endmodule

// File: rtl/ysyx_mem_arbiter.sv
// Shares the core memory port between IFU fetches and LSU loads/stores, one transaction at a time,
// with LSU priority bounded by a streak counter and a watchdog that aborts hung transactions.
module ysyx_mem_arbiter
    import ysyx_pkg::*;
#(
    parameter int BIT_W          = YSYX_W,
    parameter int MAX_LSU_STREAK = 4,
    parameter int TIMEOUT        = 255
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               ifu_avalid_i,
    input  logic [BIT_W-1:0]   ifu_addr_i,
    output logic               ifu_rvalid_o,
    output logic [BIT_W-1:0]   ifu_rdata_o,

    input  logic               lsu_avalid_i,
    input  logic               lsu_wen_i,
    input  logic [BIT_W-1:0]   lsu_addr_i,
    input  logic [BIT_W-1:0]   lsu_wdata_i,
    input  logic [BIT_W/8-1:0] lsu_wstrb_i,
    output logic               lsu_rvalid_o,
    output logic               lsu_wready_o,
    output logic [BIT_W-1:0]   lsu_rdata_o,

    output logic               err_o,

    ysyx_mem_arbiter_if.master mem
);

    arb_state_e          state_q;
    arb_state_e          state_d;
    grant_e              grant_q;
    grant_e              arb_grant;
    logic [STREAK_W-1:0] streak_q;
    logic [WDOG_W-1:0]   wdog_q;
    logic                wen_q;
    logic [BIT_W-1:0]    addr_q;
    logic [BIT_W-1:0]    wdata_q;
    logic [BIT_W/8-1:0]  wstrb_q;

    logic                streak_max;
    logic                complete;
    logic                timeout;
    logic                finish;
    logic [BIT_W-1:0]    resp_data;

    assign streak_max = (streak_q == STREAK_W'(MAX_LSU_STREAK));

    ysyx_arb_prio u_prio (
        .ifu_req    (ifu_avalid_i),
        .lsu_req    (lsu_avalid_i),
        .streak_max (streak_max),
        .grant      (arb_grant)
    );

    // Completion only counts in RESP, so stray returns in IDLE/ADDR fall on the floor.
    // A completion arriving on the last watchdog cycle still beats the abort.
    always_comb begin
        complete = 1'b0;
        if (state_q == ARB_RESP) begin
            complete = (grant_q == GNT_LSU && wen_q) ? mem.bvalid : mem.rvalid;
        end
        timeout   = (state_q != ARB_IDLE) && (wdog_q == WDOG_W'(TIMEOUT - 1)) && !complete;
        finish    = complete || timeout;
        resp_data = timeout ? '0 : mem.rdata;
    end

    always_comb begin
        state_d    = state_q;
        mem.avalid = (state_q == ARB_ADDR);
        mem.wen    = wen_q;
        mem.addr   = addr_q;
        mem.wdata  = wdata_q;
        mem.wstrb  = wstrb_q;
        case (state_q)
            ARB_IDLE: begin
                if (arb_grant != GNT_NONE) begin
                    state_d = ARB_ADDR;
                end
            end
            ARB_ADDR: begin
                if (timeout) begin
                    state_d = ARB_IDLE;
                end else if (mem.aready) begin
                    state_d = ARB_RESP;
                end
            end
            ARB_RESP: begin
                if (finish) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant and request fields are captured only while idle and then held for the whole transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_q <= GNT_NONE;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (state_q == ARB_IDLE) begin
            grant_q <= arb_grant;
            if (arb_grant == GNT_LSU) begin
                wen_q   <= lsu_wen_i;
                addr_q  <= lsu_addr_i;
                wdata_q <= lsu_wdata_i;
                wstrb_q <= lsu_wstrb_i;
            end else if (arb_grant == GNT_IFU) begin
                wen_q   <= 1'b0;
                addr_q  <= ifu_addr_i;
                wdata_q <= '0;
                wstrb_q <= '0;
            end
        end
    end

    // The streak only grows while IFU is actually waiting, so an idle fetch unit never gets starved credit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak_q <= '0;
        end else if (state_q == ARB_IDLE) begin
            if (!ifu_avalid_i || arb_grant == GNT_IFU) begin
                streak_q <= '0;
            end else if (arb_grant == GNT_LSU && !streak_max) begin
                streak_q <= streak_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_q <= '0;
        end else if (state_q == ARB_IDLE) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_q + 1'b1;
        end
    end

    // Responses are one-cycle pulses routed only to the owner; an abort looks like a normal response with err_o.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ifu_rvalid_o <= 1'b0;
            ifu_rdata_o  <= '0;
            lsu_rvalid_o <= 1'b0;
            lsu_wready_o <= 1'b0;
            lsu_rdata_o  <= '0;
            err_o        <= 1'b0;
        end else begin
            ifu_rvalid_o <= 1'b0;
            lsu_rvalid_o <= 1'b0;
            lsu_wready_o <= 1'b0;
            err_o        <= 1'b0;
            if (finish) begin
                err_o <= timeout;
                if (grant_q == GNT_IFU) begin
                    ifu_rvalid_o <= 1'b1;
                    ifu_rdata_o  <= resp_data;
                end else if (grant_q == GNT_LSU) begin
                    if (wen_q) begin
                        lsu_wready_o <= 1'b1;
                    end else begin
                        lsu_rvalid_o <= 1'b1;
                        lsu_rdata_o  <= resp_data;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_mem_arbiter.sv
// Self-checking bench for ysyx_mem_arbiter: a delay-programmable memory responder plus a
// transaction-level model that predicts latency, routing, data and error from the arbitration rules.
module tb_ysyx_mem_arbiter;

    localparam int BIT_W      = 32;
    localparam int MAX_STREAK = 4;
    localparam int TMO        = 8;

    logic              clk;
    logic              rst;
    logic              ifu_avalid_i;
    logic [BIT_W-1:0]  ifu_addr_i;
    logic              ifu_rvalid_o;
    logic [BIT_W-1:0]  ifu_rdata_o;
    logic              lsu_avalid_i;
    logic              lsu_wen_i;
    logic [BIT_W-1:0]  lsu_addr_i;
    logic [BIT_W-1:0]  lsu_wdata_i;
    logic [3:0]        lsu_wstrb_i;
    logic              lsu_rvalid_o;
    logic              lsu_wready_o;
    logic [BIT_W-1:0]  lsu_rdata_o;
    logic              err_o;

    ysyx_mem_arbiter_if #(.BIT_W(BIT_W)) mem_bus ();

    ysyx_mem_arbiter #(
        .BIT_W          (BIT_W),
        .MAX_LSU_STREAK (MAX_STREAK),
        .TIMEOUT        (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ifu_avalid_i (ifu_avalid_i),
        .ifu_addr_i   (ifu_addr_i),
        .ifu_rvalid_o (ifu_rvalid_o),
        .ifu_rdata_o  (ifu_rdata_o),
        .lsu_avalid_i (lsu_avalid_i),
        .lsu_wen_i    (lsu_wen_i),
        .lsu_addr_i   (lsu_addr_i),
        .lsu_wdata_i  (lsu_wdata_i),
        .lsu_wstrb_i  (lsu_wstrb_i),
        .lsu_rvalid_o (lsu_rvalid_o),
        .lsu_wready_o (lsu_wready_o),
        .lsu_rdata_o  (lsu_rdata_o),
        .err_o        (err_o),
        .mem          (mem_bus)
    );

    int          checks;
    int          errors;
    int          a_delay;
    int          r_delay;
    logic [31:0] resp_data;
    logic        force_rvalid;
    logic        force_bvalid;
    logic [31:0] ifu_rd_model;
    logic [31:0] lsu_rd_model;

    int          m_phase;
    int          m_cnt;
    logic        prev_avalid;
    logic        rv_drv;
    logic        bv_drv;
    logic [31:0] seen_addr;
    logic [31:0] seen_wdata;
    logic [3:0]  seen_wstrb;
    logic        seen_wen;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory responder: accepts a_delay cycles into a request, answers r_delay cycles after acceptance.
    initial begin
        mem_bus.aready = 1'b0;
        mem_bus.rvalid = 1'b0;
        mem_bus.bvalid = 1'b0;
        mem_bus.rdata  = 32'hBAD0_BAD0;
        m_phase = 0;
        m_cnt = 0;
        prev_avalid = 1'b0;
        rv_drv = 1'b0;
        bv_drv = 1'b0;
        seen_addr = '0;
        seen_wdata = '0;
        seen_wstrb = '0;
        seen_wen = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                m_phase = 0;
                mem_bus.aready = 1'b0;
                rv_drv = 1'b0;
                bv_drv = 1'b0;
            end else begin
                if (m_phase == 1 && mem_bus.aready && prev_avalid) begin
                    m_phase = 2;
                    m_cnt = 0;
                end else if (m_phase == 2 && (rv_drv || bv_drv)) begin
                    m_phase = 0;
                end
                if (ifu_rvalid_o || lsu_rvalid_o || lsu_wready_o) m_phase = 0;
                mem_bus.aready = 1'b0;
                rv_drv = 1'b0;
                bv_drv = 1'b0;
                if (m_phase == 0 && mem_bus.avalid) begin
                    m_phase = 1;
                    m_cnt = 0;
                    seen_addr = mem_bus.addr;
                    seen_wdata = mem_bus.wdata;
                    seen_wstrb = mem_bus.wstrb;
                    seen_wen = mem_bus.wen;
                end
                if (m_phase == 1) begin
                    if (!mem_bus.avalid) begin
                        m_phase = 0;
                    end else begin
                        if (m_cnt == a_delay) mem_bus.aready = 1'b1;
                        m_cnt++;
                    end
                end else if (m_phase == 2) begin
                    if (m_cnt == r_delay) begin
                        if (seen_wen) bv_drv = 1'b1;
                        else rv_drv = 1'b1;
                    end
                    m_cnt++;
                end
            end
            prev_avalid = mem_bus.avalid;
            mem_bus.rvalid = rv_drv | force_rvalid;
            mem_bus.bvalid = bv_drv | force_bvalid;
            mem_bus.rdata  = rv_drv ? resp_data : 32'hBAD0_BAD0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        checkOutput({tag, ".ctrl"}, 32'({mem_bus.avalid, mem_bus.wen, mem_bus.wstrb, ifu_rvalid_o,
                                          lsu_rvalid_o, lsu_wready_o, err_o}), 32'h0);
        checkOutput({tag, ".mem_addr"}, mem_bus.addr, 32'h0);
        checkOutput({tag, ".mem_wdata"}, mem_bus.wdata, 32'h0);
        checkOutput({tag, ".ifu_rdata"}, ifu_rdata_o, 32'h0);
        checkOutput({tag, ".lsu_rdata"}, lsu_rdata_o, 32'h0);
    endtask

    // Issues one request from an idle arbiter and waits (bounded) for any response pulse.
    task automatic applyStimulus(input bit is_lsu, input bit wen, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] wstrb,
                                 input int a_d, input int r_d, input logic [31:0] data,
                                 output int edges, output int av_cycles, output logic [2:0] pulses,
                                 output logic err_seen);
        a_delay = a_d;
        r_delay = r_d;
        resp_data = data;
        if (is_lsu) begin
            lsu_avalid_i = 1'b1;
            lsu_wen_i = wen;
            lsu_addr_i = addr;
            lsu_wdata_i = wdata;
            lsu_wstrb_i = wstrb;
        end else begin
            ifu_avalid_i = 1'b1;
            ifu_addr_i = addr;
        end
        edges = 0;
        av_cycles = 0;
        pulses = 3'b000;
        err_seen = 1'b0;
        while (pulses == 3'b000 && edges < 600) begin
            @(posedge clk);
            #1;
            edges++;
            if (mem_bus.avalid) av_cycles++;
            pulses = {ifu_rvalid_o, lsu_rvalid_o, lsu_wready_o};
            err_seen = err_o;
        end
        ifu_avalid_i = 1'b0;
        lsu_avalid_i = 1'b0;
    endtask

    // Model: the transaction finishes on cycle aD+1+rD after entering ADDR unless that passes TMO-1.
    task automatic run_txn(input string tag, input bit is_lsu, input bit wen, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb,
                           input int a_d, input int r_d, input logic [31:0] data);
        int          edges;
        int          av_cycles;
        logic [2:0]  pulses;
        logic        err_seen;
        int          k;
        bit          abort;
        logic [2:0]  exp_pulse;
        applyStimulus(is_lsu, wen, addr, wdata, wstrb, a_d, r_d, data, edges, av_cycles, pulses, err_seen);
        k = a_d + 1 + r_d;
        abort = (a_d > TMO - 1) || (k > TMO - 1);
        exp_pulse = !is_lsu ? 3'b100 : (wen ? 3'b001 : 3'b010);
        if (!is_lsu) ifu_rd_model = abort ? 32'h0 : data;
        else if (!wen) lsu_rd_model = abort ? 32'h0 : data;
        checkOutput({tag, ".latency"}, 32'(edges), 32'(abort ? TMO + 1 : k + 2));
        checkOutput({tag, ".addr_cycles"}, 32'(av_cycles), 32'((a_d > TMO - 1) ? TMO : a_d + 1));
        checkOutput({tag, ".pulse"}, 32'(pulses), 32'(exp_pulse));
        checkOutput({tag, ".err"}, 32'(err_seen), 32'(abort));
        checkOutput({tag, ".mem_addr"}, seen_addr, addr);
        checkOutput({tag, ".mem_wen"}, 32'(seen_wen), 32'(is_lsu && wen));
        if (is_lsu && wen) begin
            checkOutput({tag, ".mem_wdata"}, seen_wdata, wdata);
            checkOutput({tag, ".mem_wstrb"}, 32'(seen_wstrb), 32'(wstrb));
        end
        checkOutput({tag, ".ifu_rdata"}, ifu_rdata_o, ifu_rd_model);
        checkOutput({tag, ".lsu_rdata"}, lsu_rdata_o, lsu_rd_model);
    endtask

    initial begin
        logic [2:0]  pulses;
        logic [2:0]  exp_gnt;
        logic        any_pulse;
        int          edges;
        bit          r_lsu;
        bit          r_wen;
        int          r_ad;

        checks = 0;
        errors = 0;
        rst = 1'b0;
        ifu_avalid_i = 1'b0;
        ifu_addr_i = '0;
        lsu_avalid_i = 1'b0;
        lsu_wen_i = 1'b0;
        lsu_addr_i = '0;
        lsu_wdata_i = '0;
        lsu_wstrb_i = '0;
        force_rvalid = 1'b0;
        force_bvalid = 1'b0;
        a_delay = 0;
        r_delay = 0;
        resp_data = '0;
        ifu_rd_model = '0;
        lsu_rd_model = '0;

        repeat (3) @(posedge clk);
        #1;
        check_idle_zero("reset");
        rst = 1'b1;

        run_txn("fetch", 1'b0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 0, 0, 32'h0000_0413);
        run_txn("load", 1'b1, 1'b0, 32'h8000_0200, 32'h0, 4'h0, 1, 0, 32'hCAFE_F00D);
        run_txn("store", 1'b1, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF, 0, 1, 32'h0);

        // Both requesters held continuously: LSU gets MAX_STREAK turns, then IFU gets one.
        a_delay = 0;
        r_delay = 0;
        resp_data = 32'h1234_5678;
        lsu_wen_i = 1'b0;
        lsu_addr_i = 32'h8000_0300;
        ifu_addr_i = 32'h8000_0004;
        ifu_avalid_i = 1'b1;
        lsu_avalid_i = 1'b1;
        for (int i = 0; i < 2 * (MAX_STREAK + 1); i++) begin
            edges = 0;
            pulses = 3'b000;
            while (pulses == 3'b000 && edges < 100) begin
                @(posedge clk);
                #1;
                edges++;
                pulses = {ifu_rvalid_o, lsu_rvalid_o, lsu_wready_o};
            end
            exp_gnt = ((i % (MAX_STREAK + 1)) == MAX_STREAK) ? 3'b100 : 3'b010;
            checkOutput($sformatf("streak%0d", i), 32'(pulses), 32'(exp_gnt));
        end
        ifu_avalid_i = 1'b0;
        lsu_avalid_i = 1'b0;
        ifu_rd_model = 32'h1234_5678;
        lsu_rd_model = 32'h1234_5678;

        run_txn("hang_load", 1'b1, 1'b0, 32'h8000_0400, 32'h0, 4'h0, 1000, 0, 32'h5555_AAAA);
        run_txn("after_hang", 1'b1, 1'b0, 32'h8000_0404, 32'h0, 4'h0, 0, 0, 32'h0BAD_F00D);
        run_txn("edge_done", 1'b1, 1'b0, 32'h8000_0408, 32'h0, 4'h0, 0, TMO - 2, 32'h7777_1111);
        run_txn("edge_abort", 1'b1, 1'b0, 32'h8000_040C, 32'h0, 4'h0, 0, TMO - 1, 32'h7777_2222);
        run_txn("edge_fetch", 1'b0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 2, TMO - 4, 32'h0000_0093);
        run_txn("hang_store", 1'b1, 1'b1, 32'h8000_0500, 32'h1111_2222, 4'h3, TMO - 1, 0, 32'h0);

        for (int n = 0; n < 16; n++) begin
            r_lsu = 1'($urandom_range(0, 1));
            r_wen = r_lsu ? 1'($urandom_range(0, 1)) : 1'b0;
            r_ad = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 3));
            run_txn($sformatf("rand%0d", n), r_lsu, r_wen, $urandom, $urandom,
                    4'($urandom_range(0, 15)), r_ad, int'($urandom_range(0, 5)), $urandom);
        end

        // Reset dropped in the middle of a response wait, away from any clock edge.
        a_delay = 0;
        r_delay = 50;
        lsu_wen_i = 1'b0;
        lsu_addr_i = 32'h8000_0600;
        lsu_avalid_i = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        #3;
        rst = 1'b0;
        #1;
        check_idle_zero("mid_reset");
        lsu_avalid_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        force_rvalid = 1'b1;
        force_bvalid = 1'b1;
        any_pulse = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            any_pulse = any_pulse | ifu_rvalid_o | lsu_rvalid_o | lsu_wready_o | err_o;
        end
        force_rvalid = 1'b0;
        force_bvalid = 1'b0;
        checkOutput("stale_response", 32'(any_pulse), 32'h0);
        ifu_rd_model = 32'h0;
        lsu_rd_model = 32'h0;
        @(posedge clk);
        #1;
        run_txn("post_reset", 1'b0, 1'b0, 32'h8000_0020, 32'h0, 4'h0, 0, 0, 32'h0010_0073);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
